// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Universal WIDTH-bit shift register with a burst engine.
//
//   Single-step operations (hold, shift R/L with serial input, rotate R/L,
//   parallel load) execute on any idle cycle where en=1. A start request
//   with a shift/rotate mode launches a burst that repeats that operation
//   for len cycles (clamped to WIDTH), reporting progress on busy and
//   completion with a one-cycle done pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   en     in   run one single-step operation (idle only)
//   mode   in   [2:0] operation select
//   sin    in   serial input bit
//   pin    in   [WIDTH-1:0] parallel load data
//   start  in   burst request (idle only, priority over en)
//   len    in   [CW-1:0] burst length, values above WIDTH clamp to WIDTH
//   pout   out  [WIDTH-1:0] register contents
//   sout   out  last bit shifted or rotated out
//   busy   out  burst in progress
//   done   out  one-cycle pulse after the last burst operation
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [CW-1:0]    len,
  output logic [WIDTH-1:0] pout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;

  localparam logic [CW-1:0] LEN_MAX = CW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             sout_q, sout_d;

  logic [CW-1:0]    len_clamped;
  logic             burst_mode_ok;
  logic             exec;
  logic [2:0]       exec_op;

  assign len_clamped   = (len > LEN_MAX) ? LEN_MAX : len;
  // Only shift/rotate modes can be bursted; hold/load/reserved fall through to en.
  assign burst_mode_ok = (mode >= M_SHR) && (mode <= M_ROL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    pout_d  = pout_q;
    sout_d  = sout_q;
    exec    = 1'b0;
    exec_op = mode;

    case (state_q)
      ST_IDLE: begin
        if (start && burst_mode_ok) begin
          // Acceptance cycle only latches; the first shift happens in RUN.
          op_d = mode;
          if (len_clamped != '0) begin
            state_d = ST_RUN;
            cnt_d   = len_clamped;
          end else begin
            state_d = ST_DONE;
          end
        end else if (en) begin
          exec    = 1'b1;
          exec_op = mode;
        end
      end
      ST_RUN: begin
        exec    = 1'b1;
        exec_op = op_q;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (exec) begin
      case (exec_op)
        M_SHR: begin
          pout_d = {sin, pout_q[WIDTH-1:1]};
          sout_d = pout_q[0];
        end
        M_SHL: begin
          pout_d = {pout_q[WIDTH-2:0], sin};
          sout_d = pout_q[WIDTH-1];
        end
        M_ROR: begin
          pout_d = {pout_q[0], pout_q[WIDTH-1:1]};
          sout_d = pout_q[0];
        end
        M_ROL: begin
          pout_d = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
          sout_d = pout_q[WIDTH-1];
        end
        M_LOAD: begin
          pout_d = pin;
        end
        M_HOLD: begin
          pout_d = pout_q;
        end
        default: begin
          // Reserved encodings behave as hold.
          pout_d = pout_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= M_HOLD;
      pout_q  <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      pout_q  <= pout_d;
      sout_q  <= sout_d;
    end
  end

  assign pout = pout_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register with a WIDTH-bit register.
- Single-step modes: hold, shift right/left with serial input, rotate right/left, parallel load.
- Burst engine: on one start request it shifts or rotates automatically for a programmable number of cycles, using a busy/done handshake.
- Used as a serialiser/deserialiser and bit-manipulation stage in the shift-register library. Supersedes the fixed 4-bit bidirectional serial shifter.

Parameters:
- WIDTH, 8, register width in bits (WIDTH >= 2).
- CW, derived localparam = $clog2(WIDTH+1), width of the burst length field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- en  input  1  execute one single-step operation this cycle (idle only).
- mode  input  3  operation select, see Behaviour.
- sin  input  1  serial input bit.
- pin  input  WIDTH  parallel load data.
- start  input  1  burst request (idle only).
- len  input  CW  burst length in shifts, 0..WIDTH.
- pout  output  WIDTH  register contents (registered).
- sout  output  1  last bit shifted or rotated out (registered).
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=0, asynchronous): pout=0, sout=0, busy=0, done=0, FSM to IDLE, burst counter 0.
- Reset asserted mid-burst aborts the burst immediately, with no done pulse.
- mode encoding (R = toward LSB):
  - 000 hold.
  - 001 shift R: pout <= {sin, pout[W-1:1]}, sout <= pout[0].
  - 010 shift L: pout <= {pout[W-2:0], sin}, sout <= pout[W-1].
  - 011 rotate R: pout <= {pout[0], pout[W-1:1]}, sout <= pout[0].
  - 100 rotate L: pout <= {pout[W-2:0], pout[W-1]}, sout <= pout[W-1].
  - 101 load: pout <= pin, sout unchanged.
  - 110, 111 reserved, treated as hold.
- sout changes only on shift/rotate cycles and holds otherwise.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and mode is in 001..100: latch mode and len. No data operation occurs this cycle.
    - len>0: go to RUN, cnt <= len.
    - len=0: go to DONE.
  - If start=1 with any other mode: start is ignored and the en path applies.
  - Else if en=1: perform mode once and stay in IDLE.
  - start has priority over en.
- RUN:
  - busy=1.
  - Each cycle performs the latched operation, sampling live sin, and decrements cnt.
  - When cnt==1, perform the last operation and go to DONE.
  - start, en, mode and pin are ignored.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. A start in this cycle is ignored.
- len > WIDTH is clamped to WIDTH.
- Burst latency: len shifts are performed over len cycles, starting the cycle after start. done is asserted the cycle after the last shift.
- Back-to-back bursts: the earliest accepted start is in the cycle after DONE.

Test Plan:
- Reset values: rst=0 with random inputs → pout=8'h00, sout=0, busy=0, done=0. Release rst, mode=000, en=1 → pout stays 8'h00.
- Load then shift R: pin=8'hA5, mode=101, en=1 → pout=8'hA5. Then mode=001, sin=1 → pout=8'hD2, sout=1. Then mode=000 for 3 cycles → pout and sout hold.
- Shift L and rotates, each starting from a fresh load:
  - 8'hA5, mode=010, sin=0 → pout=8'h4A, sout=1.
  - 8'h81, mode=011 → pout=8'hC0, sout=1.
  - 8'h81, mode=100 → pout=8'h03, sout=1.
- Burst shift L: load 8'hF0, then mode=010, sin=0, start=1, len=4 →
  - busy=1 for exactly 4 cycles, pout sequence E0, C0, 80, 00.
  - sout=1 after each shift.
  - done pulses once, the cycle after pout=8'h00.
  - A start pulsed during busy has no effect.
- Burst edge cases:
  - len=0 → no busy, done pulses the next cycle, pout unchanged.
  - Rotate burst mode=011, len=8 on 8'h5A → pout returns to 8'h5A.
  - len=15 is clamped to 8.
- Reset mid-burst: rst=0 on the 2nd busy cycle of an 8-cycle burst → pout=0, busy=0 immediately, no done pulse. After release, a new start is accepted normally.
